// File: rtl/dmem_arbiter_if.sv
// Requester-side handshake bundle for one data-memory port (CPU or debug loader).
// Latency: none (wires only).
// Backpressure: req is held high until the one-cycle ack pulse.
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, we, addr, wdata, input ack, rdata, err);
    modport slave  (input req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of the single-port data memory.
// Latency: strobes one cycle after the grant edge, ack one cycle after that.
// Backpressure: a requester holds req until its ack; the loser waits one transaction.
module dmem_arbiter #(
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_arbiter_if.slave   c,
    dmem_arbiter_if.slave   d,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t        state_q, state_d;
    logic          prio_q, prio_d;      // 0 = port C, 1 = port D
    logic          port_q, port_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic          grant, gport;
    logic          sel_we, sel_err;
    logic [31:0]   sel_addr, sel_wdata;
    logic          mem_en_d, mem_we_d;
    logic [AW-1:0] mem_addr_d;
    logic [31:0]   mem_wdata_d;
    logic          c_ack_q, d_ack_q, c_err_q, d_err_q;
    logic          c_ack_d, d_ack_d, c_err_d, d_err_d;
    logic [31:0]   c_hold_q, d_hold_q, resp_dat;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        port_d      = port_q;
        we_d        = we_q;
        err_d       = err_q;
        grant       = 1'b0;
        gport       = 1'b0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        c_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        c_err_d     = 1'b0;
        d_err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (c.req || d.req) begin
                    grant = 1'b1;
                    gport = (c.req && d.req) ? prio_q : d.req;
                end
            end
            ISSUE: begin
                state_d = RESP;
                c_ack_d = ~port_q;
                d_ack_d = port_q;
                c_err_d = ~port_q & err_q;
                d_err_d = port_q & err_q;
            end
            RESP: begin
                // the acked port still shows req this cycle, so only the other port may chain
                gport = ~port_q;
                grant = port_q ? c.req : d.req;
            end
            default: ;
        endcase

        sel_we    = gport ? d.we    : c.we;
        sel_addr  = gport ? d.addr  : c.addr;
        sel_wdata = gport ? d.wdata : c.wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:AW+2] != '0);

        if (grant) begin
            state_d     = ISSUE;
            prio_d      = ~gport;
            port_d      = gport;
            we_d        = sel_we;
            err_d       = sel_err;
            mem_en_d    = ~sel_err;
            mem_we_d    = ~sel_err & sel_we;
            mem_addr_d  = sel_addr[AW+1:2];
            mem_wdata_d = sel_wdata;
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            c_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            c_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            port_q    <= port_d;
            we_q      <= we_d;
            err_q     <= err_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            c_ack_q   <= c_ack_d;
            d_ack_q   <= d_ack_d;
            c_err_q   <= c_err_d;
            d_err_q   <= d_err_d;
        end
    end

    // memory read data only arrives during RESP, so it is passed through with the ack and then held
    assign resp_dat = (we_q || err_q) ? 32'h0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            if (c_ack_q) c_hold_q <= resp_dat;
            if (d_ack_q) d_hold_q <= resp_dat;
        end
    end

    assign c.ack   = c_ack_q;
    assign d.ack   = d_ack_q;
    assign c.err   = c_err_q;
    assign d.err   = d_err_q;
    assign c.rdata = c_ack_q ? resp_dat : c_hold_q;
    assign d.rdata = d_ack_q ? resp_dat : d_hold_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous-read memory model behind it.
module tb_dmem_arbiter;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [31:0]   mem [512];
    int            total = 0;
    int            bad = 0;

    dmem_arbiter_if c_if ();
    dmem_arbiter_if d_if ();

    dmem_arbiter #(.DEPTH(512), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .c(c_if), .d(d_if),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic set_req(input bit port, input bit r, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            d_if.req = r; d_if.we = we; d_if.addr = addr; d_if.wdata = wdata;
        end else begin
            c_if.req = r; c_if.we = we; c_if.addr = addr; c_if.wdata = wdata;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // one request on one port, observed for a bounded six edges; edge 1 is the sampling edge
    task automatic single(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic er, output int ack_at, output int ack_cnt,
                          output int en_cnt, output logic [AW-1:0] ea, output logic we_seen);
        rd = 'x; er = 1'bx; ack_at = -1; ack_cnt = 0; en_cnt = 0; ea = '0; we_seen = 1'b0;
        @(negedge clk);
        set_req(port, 1, we, addr, wdata);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (mem_en) begin en_cnt++; ea = mem_addr; we_seen = mem_we; end
            if (port ? d_if.ack : c_if.ack) begin
                ack_cnt++;
                if (ack_at < 0) ack_at = k;
                rd = port ? d_if.rdata : c_if.rdata;
                er = port ? d_if.err : c_if.err;
                set_req(port, 0, 0, 0, 0);
            end
        end
    endtask

    // C loads 0x10, D loads 0x0, raised on the same edge
    task automatic both(output int ca, output int da, output int en_mask, output logic [31:0] crd, output logic [31:0] drd);
        ca = -1; da = -1; en_mask = 0; crd = 'x; drd = 'x;
        @(negedge clk);
        set_req(0, 1, 0, 32'h10, 0);
        set_req(1, 1, 0, 32'h0, 0);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            if (mem_en) en_mask |= (1 << k);
            if (c_if.ack) begin ca = k; crd = c_if.rdata; set_req(0, 0, 0, 0, 0); end
            if (d_if.ack) begin da = k; drd = d_if.rdata; set_req(1, 0, 0, 0, 0); end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({c_if.ack, d_if.ack, c_if.err, d_if.err, mem_en, mem_we} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=000000", {c_if.ack, d_if.ack, c_if.err, d_if.err, mem_en, mem_we});
        end
        total++;
        if ({c_if.rdata, d_if.rdata, mem_wdata, mem_addr} !== '0) begin
            bad++; $display("FAIL reset_data c_rdata=%h d_rdata=%h mem_wdata=%h mem_addr=%h want all 0",
                            c_if.rdata, d_if.rdata, mem_wdata, mem_addr);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er, ws; int at, ac, en; logic [AW-1:0] ea;
        single(0, 1, 32'h10, 32'hDEADBEEF, rd, er, at, ac, en, ea, ws);
        total++;
        if (en !== 1 || ea !== 9'd4 || ws !== 1'b1 || at !== 2 || ac !== 1 || er !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL c_store en=%0d addr=%0d we=%b ack_at=%0d acks=%0d err=%b rd=%h want 1 4 1 2 1 0 0",
                            en, ea, ws, at, ac, er, rd);
        end
        single(0, 0, 32'h10, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (en !== 1 || ea !== 9'd4 || ws !== 1'b0 || at !== 2 || ac !== 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL c_load en=%0d addr=%0d we=%b ack_at=%0d acks=%0d err=%b rd=%h want 1 4 0 2 1 0 deadbeef",
                            en, ea, ws, at, ac, er, rd);
        end
        single(1, 1, 32'h0, 32'h5555AAAA, rd, er, at, ac, en, ea, ws);
        total++;
        if (en !== 1 || ea !== 9'd0 || at !== 2 || er !== 1'b0 || mem[0] !== 32'h5555AAAA) begin
            bad++; $display("FAIL d_store en=%0d addr=%0d ack_at=%0d err=%b mem0=%h want 1 0 2 0 5555aaaa", en, ea, at, er, mem[0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, ws; int at, ac, en; logic [AW-1:0] ea;
        single(0, 0, 32'h13, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (en !== 0 || at !== 2 || ac !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_misaligned en=%0d ack_at=%0d acks=%0d err=%b rd=%h want 0 2 1 1 0", en, at, ac, er, rd);
        end
        single(1, 1, 32'h800, 32'hFFFFFFFF, rd, er, at, ac, en, ea, ws);
        total++;
        if (en !== 0 || at !== 2 || er !== 1'b1 || rd !== 32'h0 || mem[0] !== 32'h5555AAAA) begin
            bad++; $display("FAIL err_range en=%0d ack_at=%0d err=%b rd=%h mem0=%h want 0 2 1 0 5555aaaa", en, at, er, rd, mem[0]);
        end
    endtask

    task automatic test_simultaneous();
        int ca, da, m, at, ac, en; logic [31:0] crd, drd, rd; logic er, ws; logic [AW-1:0] ea;
        do_reset();
        both(ca, da, m, crd, drd);
        total++;
        if (ca !== 2 || da !== 4 || m !== 'b1010 || crd !== 32'hDEADBEEF || drd !== 32'h5555AAAA) begin
            bad++; $display("FAIL simul_first c_at=%0d d_at=%0d en_mask=%0h c_rd=%h d_rd=%h want 2 4 a deadbeef 5555aaaa",
                            ca, da, m, crd, drd);
        end
        // C then D were granted, so the pointer is back on C
        both(ca, da, m, crd, drd);
        total++;
        if (ca !== 2 || da !== 4) begin
            bad++; $display("FAIL simul_again c_at=%0d d_at=%0d want 2 4", ca, da);
        end
        single(0, 0, 32'h10, 32'h0, rd, er, at, ac, en, ea, ws);
        both(ca, da, m, crd, drd);
        total++;
        if (da !== 2 || ca !== 4 || drd !== 32'h5555AAAA || crd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL simul_rotated d_at=%0d c_at=%0d d_rd=%h c_rd=%h want 2 4 5555aaaa deadbeef", da, ca, drd, crd);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        do_reset();
        @(negedge clk);
        set_req(0, 1, 0, 32'h10, 0);
        set_req(1, 1, 0, 32'h0, 0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            acks += int'(c_if.ack) + int'(d_if.ack);
            total++;
            if (k % 2 == 1) begin
                if (mem_en !== 1'b1 || c_if.ack !== 1'b0 || d_if.ack !== 1'b0) begin
                    bad++; $display("FAIL b2b_issue k=%0d en=%b c_ack=%b d_ack=%b want 1 0 0", k, mem_en, c_if.ack, d_if.ack);
                end
            end else if (((k / 2) % 2) == 1) begin
                if (c_if.ack !== 1'b1 || d_if.ack !== 1'b0 || mem_en !== 1'b0 || c_if.rdata !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL b2b_c k=%0d c_ack=%b d_ack=%b en=%b c_rd=%h want 1 0 0 deadbeef",
                                    k, c_if.ack, d_if.ack, mem_en, c_if.rdata);
                end
            end else begin
                if (d_if.ack !== 1'b1 || c_if.ack !== 1'b0 || mem_en !== 1'b0 || d_if.rdata !== 32'h5555AAAA) begin
                    bad++; $display("FAIL b2b_d k=%0d d_ack=%b c_ack=%b en=%b d_rd=%h want 1 0 0 5555aaaa",
                                    k, d_if.ack, c_if.ack, mem_en, d_if.rdata);
                end
            end
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (3) begin
            @(posedge clk); #1;
            acks += int'(c_if.ack) + int'(d_if.ack);
        end
        total++;
        if (acks !== 10) begin
            bad++; $display("FAIL b2b_count acks=%0d want 10", acks);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, ws; int at, ac, en, late = 0; logic [AW-1:0] ea;
        single(0, 1, 32'h20, 32'h11112222, rd, er, at, ac, en, ea, ws);
        @(negedge clk);
        set_req(0, 1, 1, 32'h20, 32'hCAFEF00D);
        @(posedge clk); #1;
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'd8) begin
            bad++; $display("FAIL mid_issue en=%b we=%b addr=%0d want 1 1 8", mem_en, mem_we, mem_addr);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mem_en, mem_we, c_if.ack, d_if.ack, c_if.err} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            bad++; $display("FAIL mid_async en=%b we=%b c_ack=%b addr=%0d wdata=%h want all 0",
                            mem_en, mem_we, c_if.ack, mem_addr, mem_wdata);
        end
        set_req(0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            late += int'(c_if.ack) + int'(mem_en);
        end
        total++;
        if (late !== 0 || mem[8] !== 32'h11112222) begin
            bad++; $display("FAIL mid_dropped late_events=%0d mem8=%h want 0 11112222", late, mem[8]);
        end
        single(0, 0, 32'h20, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (at !== 2 || er !== 1'b0 || rd !== 32'h11112222) begin
            bad++; $display("FAIL mid_after ack_at=%0d err=%b rd=%h want 2 0 11112222", at, er, rd);
        end
    endtask

    task automatic test_rdata_hold();
        logic [31:0] rd; logic er, ws; int at, ac, en; logic [AW-1:0] ea;
        single(1, 1, 32'h30, 32'h1234, rd, er, at, ac, en, ea, ws);
        single(1, 0, 32'h30, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (rd !== 32'h1234 || d_if.rdata !== 32'h1234) begin
            bad++; $display("FAIL hold_load rd=%h d_rdata=%h want 1234", rd, d_if.rdata);
        end
        single(0, 0, 32'h10, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (d_if.rdata !== 32'h1234 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_c_load d_rdata=%h c_rd=%h want 1234 deadbeef", d_if.rdata, rd);
        end
        single(0, 1, 32'h40, 32'h77, rd, er, at, ac, en, ea, ws);
        total++;
        if (d_if.rdata !== 32'h1234) begin
            bad++; $display("FAIL hold_c_store d_rdata=%h want 1234", d_if.rdata);
        end
        single(1, 0, 32'h10, 32'h0, rd, er, at, ac, en, ea, ws);
        total++;
        if (d_if.rdata !== 32'hDEADBEEF) begin
            bad++; $display("FAIL hold_update d_rdata=%h want deadbeef", d_if.rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        test_reset();
        test_store_load();
        test_errors();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_rdata_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
